// File: rtl/am_carrier_nco.sv
// AM carrier NCO: phase accumulator addressing an external sine ROM, plus a
// two-stage pipeline that scales the ROM carrier by the envelope 1 + m*msg.
module am_carrier_nco #(
  parameter int unsigned PHASE_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               sync_clr,
  input  logic [PHASE_W-1:0] fcw,
  input  logic               fcw_load,
  input  logic [7:0]         msg,
  input  logic               msg_valid,
  input  logic [7:0]         depth,
  output logic [7:0]         rom_ad,
  output logic               rom_ce,
  output logic               rom_oce,
  input  logic [7:0]         rom_dout,
  output logic [15:0]        am_out,
  output logic               am_valid
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_d;
  logic [PHASE_W-1:0] fcw_r;
  logic [7:0]         msg_hold;
  logic [8:0]         env_r;
  logic [8:0]         env_d;
  logic               v1;

  logic signed [16:0] mod_prod;
  logic signed [15:0] am_prod;

  // Phase next-state: clear beats run, run wraps modulo 2^PHASE_W.
  always_comb begin
    phase_d = phase;
    if (sync_clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = phase + fcw_r;
    end
  end

  // Envelope and carrier products; ranges are bounded so no saturation is needed.
  always_comb begin
    mod_prod = $signed({1'b0, depth}) * $signed(msg_hold);
    // Arithmetic shift gives floor division by 256; result lands in 0..254.
    env_d    = 9'(mod_prod >>> 8) + 9'd128;
    am_prod  = $signed(rom_dout) * $signed({1'b0, env_r});
  end

  // Phase accumulator and frequency word; fcw_r update never affects this edge's step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      fcw_r <= '0;
    end else begin
      phase <= phase_d;
      if (fcw_load) begin
        fcw_r <= fcw;
      end
    end
  end

  // Message hold register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_hold <= '0;
    end else if (msg_valid) begin
      msg_hold <= msg;
    end
  end

  // Stage 1: envelope alongside the ROM read; holds while stopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      env_r <= '0;
      v1    <= 1'b0;
    end else begin
      v1 <= en;
      if (en) begin
        env_r <= env_d;
      end
    end
  end

  // Stage 2: modulated output, held whenever no sample is in stage 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      am_out   <= '0;
      am_valid <= 1'b0;
    end else begin
      am_valid <= v1;
      if (v1) begin
        am_out <= am_prod;
      end
    end
  end

  // ROM interface: address straight from the phase register.
  always_comb begin
    rom_ad  = phase[PHASE_W-1 -: 8];
    rom_ce  = en & ~reset;
    rom_oce = ~reset;
  end

endmodule

// File: tb/tb_am_carrier_nco.sv
// Scoreboard bench for am_carrier_nco with a behavioural sine ROM and
// a reference model built from the arithmetic rules of the block.
module tb_am_carrier_nco;

  localparam int PW = 24;

  logic          clk;
  logic          reset;
  logic          en;
  logic          sync_clr;
  logic [PW-1:0] fcw;
  logic          fcw_load;
  logic [7:0]    msg;
  logic          msg_valid;
  logic [7:0]    depth;
  logic [7:0]    rom_ad;
  logic          rom_ce;
  logic          rom_oce;
  logic [7:0]    rom_dout;
  logic [15:0]   am_out;
  logic          am_valid;

  am_carrier_nco #(.PHASE_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sync_clr  (sync_clr),
    .fcw       (fcw),
    .fcw_load  (fcw_load),
    .msg       (msg),
    .msg_valid (msg_valid),
    .depth     (depth),
    .rom_ad    (rom_ad),
    .rom_ce    (rom_ce),
    .rom_oce   (rom_oce),
    .rom_dout  (rom_dout),
    .am_out    (am_out),
    .am_valid  (am_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sine table, 127*sin(2*pi*a/256) rounded to nearest.
  int sine [256];
  initial begin
    for (int a = 0; a < 256; a++) begin
      real x;
      x = 127.0 * $sin(2.0 * 3.14159265358979 * a / 256.0);
      sine[a] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    end
  end

  // Synchronous ROM: data valid one clock after the address edge with ce.
  logic [7:0] rom_q;
  initial rom_q = 8'h00;
  always @(posedge clk) if (rom_ce) rom_q <= 8'(sine[rom_ad]);
  assign rom_dout = rom_q;

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  exp_t          q[$];
  int            cyc = 0;
  logic [PW-1:0] phase_m = '0;
  logic [PW-1:0] fcw_m = '0;
  int            msg_m = 0;
  logic [15:0]   last_out = 16'h0000;
  int            vectors = 0;
  int            miscompares = 0;

  function automatic int floor256(input int p);
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Reference model: each enabled edge yields one sample of sine(addr)*envelope.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      phase_m  = '0;
      fcw_m    = '0;
      msg_m    = 0;
      last_out = 16'h0000;
      q.delete();
    end else begin
      if (en) begin
        exp_t e;
        int   env;
        env   = 128 + floor256(int'(depth) * msg_m);
        e.due = cyc + 1;
        e.val = 16'(sine[phase_m[PW-1 -: 8]] * env);
        q.push_back(e);
      end
      if (sync_clr) phase_m = '0;
      else if (en) phase_m = phase_m + fcw_m;
      if (fcw_load) fcw_m = fcw;
      if (msg_valid) msg_m = int'($signed(msg));
    end
  end

  // Monitor: compares ROM interface every cycle and pops samples when due.
  always @(negedge clk) begin
    if (reset) begin
      check("reset_am_valid", 32'(am_valid), 32'd0);
      check("reset_am_out", 32'(am_out), 32'd0);
      check("reset_rom_ad", 32'(rom_ad), 32'd0);
      check("reset_rom_ce", 32'(rom_ce), 32'd0);
      check("reset_rom_oce", 32'(rom_oce), 32'd0);
    end else begin
      check("rom_ad", 32'(rom_ad), 32'(phase_m[PW-1 -: 8]));
      check("rom_ce", 32'(rom_ce), 32'(en));
      check("rom_oce", 32'(rom_oce), 32'd1);
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        last_out = e.val;
        check("am_valid", 32'(am_valid), 32'd1);
        check("am_out", 32'(am_out), 32'(e.val));
      end else begin
        check("am_valid_idle", 32'(am_valid), 32'd0);
        check("am_out_hold", 32'(am_out), 32'(last_out));
      end
    end
  end

  task automatic drive(input logic e, input logic c, input logic l, input logic [PW-1:0] f,
                       input logic mv, input logic [7:0] m, input logic [7:0] d, input int n);
    en        = e;
    sync_clr  = c;
    fcw_load  = l;
    fcw       = f;
    msg_valid = mv;
    msg       = m;
    depth     = d;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0; sync_clr = 1'b0; fcw_load = 1'b0; fcw = '0;
    msg_valid = 1'b0; msg = 8'h00; depth = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, '0, 0, 8'h00, 8'h00, 2);

    // Carrier only: rom_ad steps by one per cycle, address 0x40 gives 0x3F80.
    drive(1, 1, 1, 24'h010000, 1, 8'h00, 8'h00, 1);
    drive(1, 0, 0, '0, 0, 8'h00, 8'h00, 80);

    // Full-depth envelope extremes.
    drive(1, 0, 0, '0, 1, 8'd127, 8'd255, 1);
    drive(1, 0, 0, '0, 0, 8'd127, 8'd255, 40);
    drive(1, 0, 0, '0, 1, 8'h80, 8'd255, 1);
    drive(1, 0, 0, '0, 0, 8'h80, 8'd255, 20);

    // Phase wrap: reach 0xFFFF00, then step by 0x200 across zero.
    drive(1, 1, 1, 24'hFFFF00, 0, 8'h00, 8'd100, 1);
    drive(1, 0, 1, 24'h000200, 0, 8'h00, 8'd100, 1);
    drive(1, 0, 0, '0, 0, 8'h00, 8'd100, 4);

    // Drain after 10 run cycles, phase frozen while stopped.
    drive(1, 0, 1, 24'h013579, 1, 8'h35, 8'd200, 10);
    drive(0, 0, 0, '0, 0, 8'h00, 8'd10, 6);

    // Mid-run reset discards in-flight samples.
    drive(1, 0, 0, '0, 0, 8'h00, 8'd50, 5);
    reset = 1'b1;
    drive(1, 0, 0, '0, 0, 8'h00, 8'd50, 1);
    reset = 1'b0;
    drive(1, 1, 1, 24'h024680, 1, 8'hC3, 8'd77, 8);

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      logic [PW-1:0] f;
      f = PW'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 19) == 0), f, ($urandom_range(0, 2) == 0),
            8'($urandom), 8'($urandom), 1);
    end
    reset = 1'b0;
    drive(0, 0, 0, '0, 0, 8'h00, 8'h00, 6);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/am_carrier_nco.md
AM_CARRIER_NCO -- requirements
Module: am_carrier_nco

Interface
REQ-001 Parameter PHASE_W, default 24, phase accumulator width in bits (legal 9..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  run enable for the phase accumulator and the output pipeline.
REQ-005 sync_clr  input  1  synchronous phase clear.
REQ-006 fcw  input  PHASE_W  frequency control word, unsigned.
REQ-007 fcw_load  input  1  strobe; latches fcw.
REQ-008 msg  input  8  modulating sample, two's complement.
REQ-009 msg_valid  input  1  strobe; latches msg.
REQ-010 depth  input  8  modulation index m = depth/256, unsigned.
REQ-011 rom_ad  output  8  carrier sine ROM address.
REQ-012 rom_ce  output  1  ROM clock enable.
REQ-013 rom_oce  output  1  ROM output enable.
REQ-014 rom_dout  input  8  ROM data, signed sine (-127..127), valid one clk after the address edge with rom_ce=1.
REQ-015 am_out  output  16  AM sample, two's complement.
REQ-016 am_valid  output  1  am_out holds a new sample this cycle.

Function
REQ-017 fcw_load=1 SHALL capture fcw into fcw_r at the edge; the accumulator SHALL use only fcw_r.
REQ-018 Phase update priority: sync_clr=1 -> phase<=0; else en=1 -> phase<=phase+fcw_r mod 2^PHASE_W (wrap, no carry out); else hold.
REQ-019 rom_ad SHALL equal phase[PHASE_W-1:PHASE_W-8] combinationally from the phase register.
REQ-020 rom_ce SHALL equal en and rom_oce SHALL be constant 1; both SHALL be 0 while reset=1.
REQ-021 msg_valid=1 SHALL capture msg into msg_hold; otherwise msg_hold holds.
REQ-022 Stage 1, each edge with en=1: env_r <= 128 + floor(depth*msg_hold/256), signed arithmetic with arithmetic shift; env_r is 9-bit unsigned, range 0..254.
REQ-023 Stage 2, each edge with v1=1: am_out <= signed(rom_dout)*env_r; the result range is -32258..32258 and SHALL NOT saturate or overflow.
REQ-024 Valid pipeline: v1 <= en; am_valid <= v1; am_out SHALL hold its value whenever v1=0.
REQ-025 Latency: a rom_ad value presented at an edge with en=1 SHALL appear as am_out, with am_valid=1, two edges later.
REQ-026 Simultaneous sync_clr and en: the clear wins, and the ROM read at that edge uses the pre-clear rom_ad.
REQ-027 Simultaneous fcw_load and en: the phase increment at that edge uses the old fcw_r.
REQ-028 When en falls, am_valid SHALL stay 1 for exactly one further cycle (the drain), then 0; phase and env_r SHALL hold.

Reset
REQ-029 While reset=1 the block SHALL hold phase=0, fcw_r=0, msg_hold=0, env_r=0, v1=0, am_out=0, am_valid=0, rom_ad=0, rom_ce=0.
REQ-030 An asserted reset mid-run SHALL discard all in-flight samples; after release, the first am_valid SHALL occur no earlier than 2 edges after en=1.

Verification
REQ-031 Reset pulse mid-run with en=1 -> all outputs 0 within the reset cycle; after release with en=1, am_valid is first 1 at the 2nd edge.
REQ-032 fcw_load with fcw=0x010000, depth=0, en=1 -> rom_ad steps 00,01,02,...; rom_ad=0x40 (rom_dout=0x7F) -> am_out=0x3F80 two edges later.
REQ-033 depth=255, msg=127 -> env_r=254, carrier 0x7F -> am_out=0x7E02; depth=255, msg=-128 -> env_r=0 -> am_out=0x0000.
REQ-034 phase=0xFFFF00, fcw_r=0x000200, en=1 -> phase=0x000100 next edge, rom_ad goes FF->00 with no glitch.
REQ-035 en dropped after 10 run cycles -> am_valid is 1 for one more edge then 0; rom_ce=0 and phase frozen while en=0.
REQ-036 sync_clr, fcw_load and en all asserted together -> phase=0, fcw_r updated, and the next increment uses the new fcw_r.
